// File: rtl/fetch_to_decode_receiver.sv
// Decode-side endpoint of the fetch-to-decode bus: strobes packets off the bus into a small FIFO
// and hands them to the decoder on valid/ready. Optional counters are enabled with `define RX_STATS_EN.
module fetch_to_decode_receiver #(
  parameter int PKT_W = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_busy,
  input  logic [PKT_W-1:0] bus_data,
  output logic             bus_recv,
  input  logic             flush,
  output logic             dec_valid,
  output logic [PKT_W-1:0] dec_data,
  input  logic             dec_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic [31:0]      stat_accepted,
  output logic [31:0]      stat_dropped
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {ACTIVE, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop, pop_eff, space, accept;

  assign dec_valid = (cnt != '0);
  assign dec_data  = dec_valid ? mem[rd_ptr] : '0;
  assign occupancy = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACTIVE;
    else        state <= state_nxt;
  end

  // A flush seen in either state (re)starts the one-cycle FLUSH window that swallows the stale fetch.
  always_comb begin
    state_nxt = ACTIVE;
    pop       = dec_valid && dec_ready;
    pop_eff   = 1'b0;
    space     = 1'b0;
    bus_recv  = 1'b0;
    accept    = 1'b0;
    if (flush) state_nxt = FLUSH;
    pop_eff  = pop && !flush;
    space    = (cnt < CNT_W'(DEPTH)) || pop;
    bus_recv = rst_n && bus_busy && ((state == FLUSH) || flush || space);
    accept   = bus_recv && (state == ACTIVE) && !flush;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(accept) - CNT_W'(pop_eff);
    end
  end

`ifdef RX_STATS_EN
  logic        discard;
  logic [31:0] acc_q, drop_q;

  // Every strobed packet that is not written is a drop; a flush also drops whatever is buffered.
  assign discard = bus_recv && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q <= acc_q + 32'(accept);
      if (flush) drop_q <= drop_q + 32'(cnt) + 32'(discard);
      else       drop_q <= drop_q + 32'(discard);
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drop_q;
`else
  assign stat_accepted = 32'h0;
  assign stat_dropped  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_to_decode_receiver.sv
// Scoreboard bench for fetch_to_decode_receiver: expected packets are queued when posted on the bus
// and compared in order whenever the decoder handshake fires.
module tb_fetch_to_decode_receiver;

  localparam int PKT_W = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bus_busy;
  logic [PKT_W-1:0] bus_data;
  logic             bus_recv;
  logic             flush;
  logic             dec_valid;
  logic [PKT_W-1:0] dec_data;
  logic             dec_ready;
  logic [CNT_W-1:0] occupancy;
  logic [31:0]      stat_accepted;
  logic [31:0]      stat_dropped;

  fetch_to_decode_receiver #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus_busy(bus_busy), .bus_data(bus_data), .bus_recv(bus_recv),
    .flush(flush), .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
    .occupancy(occupancy), .stat_accepted(stat_accepted), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  logic [PKT_W-1:0] sbq[$];
  int nchk = 0;
  int nerr = 0;
  int pushed = 0;
  int delivered = 0;
  bit rnd_ready = 1'b0;
  logic [31:0] acc0, drop0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [PKT_W-1:0] p);
    sbq.push_back(p);
    pushed++;
  endtask

  // Called once per cycle with the inputs for the coming edge already settled.
  task automatic sb_pop();
    logic [PKT_W-1:0] e;
    if (dec_valid && dec_ready && !flush) begin
      if (sbq.size() == 0) begin
        check("extra_pkt", {63'd0, dec_valid}, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("order", dec_data, e);
        delivered++;
      end
    end
  endtask

  task automatic tick();
    #1;
    sb_pop();
    @(negedge clk);
  endtask

  // Hold a packet on the bus until the receiver strobes it, as the fetch-side sender would.
  task automatic post(input logic [PKT_W-1:0] p);
    bit got;
    got = 1'b0;
    bus_busy = 1'b1;
    bus_data = p;
    for (int n = 0; n < 100 && !got; n++) begin
      if (rnd_ready) dec_ready = 1'($urandom_range(0, 1));
      #1;
      got = bus_recv;
      sb_pop();
      @(negedge clk);
    end
    if (!got) check("post_timeout", {63'd0, bus_recv}, 64'd1);
    bus_busy = 1'b0;
  endtask

  task automatic drain(input bit random_ready);
    for (int n = 0; n < 300 && sbq.size() != 0; n++) begin
      dec_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    check("drain_left", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_busy = 1'b0;
    bus_data = '0;
    flush = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {63'd0, dec_valid}, 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_data", dec_data, 64'd0);
    check("rst_recv", {63'd0, bus_recv}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single packet: strobe now, decoder sees it one cycle later
    sb_push(64'h0000_1000_DEAD_BEEF);
    dec_ready = 1'b1;
    bus_busy = 1'b1;
    bus_data = 64'h0000_1000_DEAD_BEEF;
    #1;
    check("single_recv", {63'd0, bus_recv}, 64'd1);
    check("single_nobypass", {63'd0, dec_valid}, 64'd0);
    sb_pop();
    @(negedge clk);
    bus_busy = 1'b0;
    check("single_valid", {63'd0, dec_valid}, 64'd1);
    check("single_data", dec_data, 64'h0000_1000_DEAD_BEEF);
    tick();
    check("single_gone", {63'd0, dec_valid}, 64'd0);

    // Fill to DEPTH, fifth packet held until a pop frees a slot in the same cycle
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_push(64'hA000_0000_0000_0000 + 64'(i));
      post(64'hA000_0000_0000_0000 + 64'(i));
    end
    sb_push(64'hA000_0000_0000_0004);
    bus_busy = 1'b1;
    bus_data = 64'hA000_0000_0000_0004;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("full_hold", {63'd0, bus_recv}, 64'd0);
      check("full_occ", 64'(occupancy), 64'd4);
      sb_pop();
      @(negedge clk);
    end
    check("full_head", dec_data, 64'hA000_0000_0000_0000);
    dec_ready = 1'b1;
    #1;
    check("full_pop_recv", {63'd0, bus_recv}, 64'd1);
    sb_pop();
    @(negedge clk);
    bus_busy = 1'b0;
    check("full_occ_kept", 64'(occupancy), 64'd4);
    drain(1'b0);
    check("full_empty", 64'(occupancy), 64'd0);

    // Flush with 3 buffered, packet on the bus, and a stale packet the next cycle
    dec_ready = 1'b0;
    acc0 = stat_accepted;
    for (int i = 0; i < 3; i++) post(64'hF000_0000_0000_0000 + 64'(i));
    check("fl_occ3", 64'(occupancy), 64'd3);
    drop0 = stat_dropped;
    flush = 1'b1;
    bus_busy = 1'b1;
    bus_data = 64'hBAD0_0000_0000_0001;
    #1;
    check("fl_recv", {63'd0, bus_recv}, 64'd1);
    sb_pop();
    @(negedge clk);
    flush = 1'b0;
    bus_data = 64'hBAD0_0000_0000_0002;
    check("fl_occ0", 64'(occupancy), 64'd0);
    check("fl_valid0", {63'd0, dec_valid}, 64'd0);
    #1;
    check("fl_stale_recv", {63'd0, bus_recv}, 64'd1);
    sb_pop();
    @(negedge clk);
    bus_busy = 1'b0;
    dec_ready = 1'b1;
    repeat (3) tick();
    check("fl_still_empty", 64'(occupancy), 64'd0);
    check("fl_no_valid", {63'd0, dec_valid}, 64'd0);
`ifdef RX_STATS_EN
    check("fl_dropped", 64'(stat_dropped - drop0), 64'd5);
    check("fl_accepted", 64'(stat_accepted - acc0), 64'd3);
`else
    check("fl_dropped", 64'(stat_dropped), 64'd0);
    check("fl_accepted", 64'(stat_accepted), 64'd0);
`endif

    // Asynchronous reset with two buffered packets and one waiting on the bus
    dec_ready = 1'b0;
    post(64'hC000_0000_0000_0001);
    post(64'hC000_0000_0000_0002);
    check("rs_occ2", 64'(occupancy), 64'd2);
    bus_busy = 1'b1;
    bus_data = 64'hC000_0000_0000_0003;
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_valid", {63'd0, dec_valid}, 64'd0);
    check("rs_occ", 64'(occupancy), 64'd0);
    check("rs_recv", {63'd0, bus_recv}, 64'd0);
    check("rs_data", dec_data, 64'd0);
    check("rs_acc", 64'(stat_accepted), 64'd0);
    check("rs_drop", 64'(stat_dropped), 64'd0);
    @(negedge clk);
    bus_busy = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Twelve back-to-back packets with a random decoder: pointers wrap three times
    rnd_ready = 1'b1;
    delivered = 0;
    pushed = 0;
    for (int i = 0; i < 12; i++) begin
      sb_push(64'h5500_0000_0000_0000 + 64'(i * 17));
      post(64'h5500_0000_0000_0000 + 64'(i * 17));
    end
    rnd_ready = 1'b0;
    drain(1'b1);
    check("stream_count", 64'(delivered), 64'(pushed));
    check("stream_empty", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
